// File: rtl/amstrad_vram_fetch_if.sv
// amstrad_vram_fetch_if
// Groups the Gate Array / CRTC / SDRAM video-port signals of the VRAM fetch
// unit into one bundle.
//   master : drives timing, CRTC, shift control and VRAM read data
//   slave  : the fetch unit; drives vram_addr, vram_d, byte_strobe
// Parameter BYTES sets the width of vram_din (8*BYTES).
interface amstrad_vram_fetch_if #(
  parameter int BYTES = 2
);
  logic               cpu_n;
  logic               ras_n;
  logic               cas_n;
  logic [13:0]        crtc_ma;
  logic [4:0]         crtc_ra;
  logic               crtc_de;
  logic               shift_en;
  logic [3:0]         shift_cnt;
  logic [8*BYTES-1:0] vram_din;
  logic [14:0]        vram_addr;
  logic [7:0]         vram_d;
  logic               byte_strobe;

  modport master (
    output cpu_n, ras_n, cas_n, crtc_ma, crtc_ra, crtc_de,
           shift_en, shift_cnt, vram_din,
    input  vram_addr, vram_d, byte_strobe
  );

  modport slave (
    input  cpu_n, ras_n, cas_n, crtc_ma, crtc_ra, crtc_de,
           shift_en, shift_cnt, vram_din,
    output vram_addr, vram_d, byte_strobe
  );
endinterface

// File: rtl/amstrad_vram_fetch.sv
// amstrad_vram_fetch
// Video-RAM fetch unit: forms the CRTC VRAM word address, walks the bytes of
// each BYTES-wide VRAM word one per CAS cycle and optionally delays the byte
// stream by up to MAX_SHIFT bytes.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   vram_if  amstrad_vram_fetch_if.slave (timing, CRTC, shift control,
//            vram_din in; vram_addr, vram_d, byte_strobe out)
// Build option: define VRAM_FETCH_BLANK_MASK_EN to zero bytes entering the
// delay line while crtc_de is low. The direct (zero delay) path is never
// masked.
module amstrad_vram_fetch #(
  parameter int BYTES     = 2,
  parameter int MAX_SHIFT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  amstrad_vram_fetch_if.slave  vram_if
);

  localparam int BSEL_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [BSEL_W-1:0] bsel_q, bsel_d;
  logic              cas_old_q;
  logic [14:0]       addr_q, addr_d;
  logic [7:0]        d_q, d_d;
  logic              strobe_q;
  logic [7:0]        dl_q [MAX_SHIFT];

  logic              byte_event;
  logic              cas_rise;
  logic [3:0]        k;
  logic [7:0]        cur_byte;
  logic [7:0]        tap;
  logic [7:0]        m;

  // Only the first low cycle of CAS inside a video slot is a byte event.
  assign byte_event = vram_if.cpu_n & ~vram_if.ras_n & ~vram_if.cas_n & cas_old_q;
  assign cas_rise   = vram_if.cas_n & ~cas_old_q;

  always_comb begin
    k = 4'd0;
    if (vram_if.shift_en) begin
      if (vram_if.shift_cnt > 4'(MAX_SHIFT)) k = 4'(MAX_SHIFT);
      else                                   k = vram_if.shift_cnt;
    end

    cur_byte = 8'h00;
    for (int i = 0; i < BYTES; i++) begin
      if (bsel_q == BSEL_W'(i)) cur_byte = vram_if.vram_din[8*i +: 8];
    end

    // tap = dl[k-1]; compare form keeps the index width clean for any depth
    tap = 8'h00;
    for (int i = 0; i < MAX_SHIFT; i++) begin
      if (k == 4'(i + 1)) tap = dl_q[i];
    end

`ifdef VRAM_FETCH_BLANK_MASK_EN
    m = vram_if.crtc_de ? cur_byte : 8'h00;
`else
    m = cur_byte;
`endif

    addr_d = addr_q;
    if (vram_if.cpu_n)
      addr_d = {vram_if.crtc_ma[13:12], vram_if.crtc_ra[2:0], vram_if.crtc_ma[9:0]};

    // CPU slot clear takes priority over a coincident CAS rising edge.
    bsel_d = bsel_q;
    if (!vram_if.cpu_n) begin
      bsel_d = '0;
    end else if (cas_rise && !vram_if.ras_n) begin
      if (bsel_q == BSEL_W'(BYTES - 1)) bsel_d = '0;
      else                              bsel_d = bsel_q + BSEL_W'(1);
    end

    d_d = d_q;
    if (byte_event) d_d = (k == 4'd0) ? cur_byte : tap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bsel_q    <= '0;
      cas_old_q <= 1'b1;
      addr_q    <= '0;
      d_q       <= '0;
      strobe_q  <= 1'b0;
      for (int i = 0; i < MAX_SHIFT; i++) dl_q[i] <= 8'h00;
    end else begin
      bsel_q    <= bsel_d;
      cas_old_q <= vram_if.cas_n;
      addr_q    <= addr_d;
      d_q       <= d_d;
      strobe_q  <= byte_event;
      if (byte_event) begin
        dl_q[0] <= m;
        for (int i = 1; i < MAX_SHIFT; i++) dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign vram_if.vram_addr   = addr_q;
  assign vram_if.vram_d      = d_q;
  assign vram_if.byte_strobe = strobe_q;

  // MA[11:10] and RA[4:3] do not take part in the VRAM address.
  logic unused_bits;
  assign unused_bits = ^{vram_if.crtc_ma[11:10], vram_if.crtc_ra[4:3], vram_if.crtc_de};

endmodule

// File: tb/tb_amstrad_vram_fetch.sv
// Bench for amstrad_vram_fetch: a 2-byte/1-deep instance and a 4-byte/3-deep
// instance share one control waveform. The reference model keeps the history
// of bytes pushed into the delay path since reset and a per-slot CAS count.
module tb_amstrad_vram_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_n, ras_n, cas_n, crtc_de, shift_en;
  logic [13:0] crtc_ma;
  logic [4:0]  crtc_ra;
  logic [3:0]  shift_cnt;
  logic [15:0] din_a;
  logic [31:0] din_b;

  int total = 0;
  int bad = 0;

  logic [7:0] hist_a[$];
  logic [7:0] hist_b[$];
  int         idx_a, idx_b;
  logic [7:0] last_a, last_b;

  always #5 clk = ~clk;

  amstrad_vram_fetch_if #(.BYTES(2)) bus_a ();
  amstrad_vram_fetch_if #(.BYTES(4)) bus_b ();

  assign bus_a.cpu_n = cpu_n;     assign bus_b.cpu_n = cpu_n;
  assign bus_a.ras_n = ras_n;     assign bus_b.ras_n = ras_n;
  assign bus_a.cas_n = cas_n;     assign bus_b.cas_n = cas_n;
  assign bus_a.crtc_ma = crtc_ma; assign bus_b.crtc_ma = crtc_ma;
  assign bus_a.crtc_ra = crtc_ra; assign bus_b.crtc_ra = crtc_ra;
  assign bus_a.crtc_de = crtc_de; assign bus_b.crtc_de = crtc_de;
  assign bus_a.shift_en = shift_en;   assign bus_b.shift_en = shift_en;
  assign bus_a.shift_cnt = shift_cnt; assign bus_b.shift_cnt = shift_cnt;
  assign bus_a.vram_din = din_a;  assign bus_b.vram_din = din_b;

  amstrad_vram_fetch #(.BYTES(2), .MAX_SHIFT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .vram_if(bus_a));
  amstrad_vram_fetch #(.BYTES(4), .MAX_SHIFT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .vram_if(bus_b));

  function automatic int eff_k(input int max_shift);
    if (!shift_en) return 0;
    return (int'(shift_cnt) > max_shift) ? max_shift : int'(shift_cnt);
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    idx_a = 0;
    idx_b = 0;
    last_a = 8'h00;
    last_b = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // One full CAS cycle: 2 clk low, 2 clk high. drop_cpu puts a CPU slot on
  // the clk where CAS rises, which must restart the byte walk at byte 0.
  task automatic cas_cycle(input bit drop_cpu);
    logic [7:0] ba, bb, ma, mb;
    int ka, kb;
    @(negedge clk);
    cas_n = 1'b0;
    ba = din_a[8*idx_a +: 8];
    bb = din_b[8*idx_b +: 8];
    ka = eff_k(1);
    kb = eff_k(3);
    if (ka == 0) last_a = ba;
    else if (hist_a.size() >= ka) last_a = hist_a[hist_a.size()-ka];
    else last_a = 8'h00;
    if (kb == 0) last_b = bb;
    else if (hist_b.size() >= kb) last_b = hist_b[hist_b.size()-kb];
    else last_b = 8'h00;
`ifdef VRAM_FETCH_BLANK_MASK_EN
    ma = crtc_de ? ba : 8'h00;
    mb = crtc_de ? bb : 8'h00;
`else
    ma = ba;
    mb = bb;
`endif
    hist_a.push_back(ma);
    hist_b.push_back(mb);
    if (hist_a.size() > 16) void'(hist_a.pop_front());
    if (hist_b.size() > 16) void'(hist_b.pop_front());

    @(posedge clk); #1;
    total += 4;
    if (bus_a.byte_strobe !== 1'b1) begin bad++; $display("FAIL strobe_a got=%b want=1", bus_a.byte_strobe); end
    if (bus_b.byte_strobe !== 1'b1) begin bad++; $display("FAIL strobe_b got=%b want=1", bus_b.byte_strobe); end
    if (bus_a.vram_d !== last_a) begin bad++; $display("FAIL byte_a got=%h want=%h", bus_a.vram_d, last_a); end
    if (bus_b.vram_d !== last_b) begin bad++; $display("FAIL byte_b got=%h want=%h", bus_b.vram_d, last_b); end

    @(negedge clk);
    @(posedge clk); #1;
    total += 4;
    if (bus_a.byte_strobe !== 1'b0) begin bad++; $display("FAIL strobe_a_pulse got=%b want=0", bus_a.byte_strobe); end
    if (bus_b.byte_strobe !== 1'b0) begin bad++; $display("FAIL strobe_b_pulse got=%b want=0", bus_b.byte_strobe); end
    if (bus_a.vram_d !== last_a) begin bad++; $display("FAIL hold_a got=%h want=%h", bus_a.vram_d, last_a); end
    if (bus_b.vram_d !== last_b) begin bad++; $display("FAIL hold_b got=%h want=%h", bus_b.vram_d, last_b); end

    @(negedge clk);
    cas_n = 1'b1;
    if (drop_cpu) cpu_n = 1'b0;
    @(negedge clk);
    cpu_n = 1'b1;
    if (drop_cpu) begin
      idx_a = 0;
      idx_b = 0;
    end else begin
      idx_a = (idx_a + 1) % 2;
      idx_b = (idx_b + 1) % 4;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total += 3;
    if (bus_a.vram_addr !== 15'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus_a.vram_addr); end
    if (bus_a.vram_d !== 8'h00) begin bad++; $display("FAIL rst_d got=%h want=00", bus_a.vram_d); end
    if (bus_b.byte_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want=0", bus_b.byte_strobe); end
    reset_n = 1'b1;
    model_reset();
    shift_en = 1'b0;
    din_a = 16'h3C5A;
    din_b = 32'h0F1E2D3C;
    cas_cycle(0);
    // Mid-fetch async reset, asserted between clock edges while CAS is low.
    @(negedge clk);
    cas_n = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    total += 4;
    if (bus_a.vram_addr !== 15'h0) begin bad++; $display("FAIL midrst_addr got=%h want=0", bus_a.vram_addr); end
    if (bus_a.vram_d !== 8'h00) begin bad++; $display("FAIL midrst_d got=%h want=00", bus_a.vram_d); end
    if (bus_a.byte_strobe !== 1'b0) begin bad++; $display("FAIL midrst_strobe got=%b want=0", bus_a.byte_strobe); end
    if (bus_b.vram_d !== 8'h00) begin bad++; $display("FAIL midrst_d_b got=%h want=00", bus_b.vram_d); end
    @(negedge clk);
    cas_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    din_a = 16'h7E81;
    cas_cycle(0);
    total++;
    if (bus_a.vram_d !== 8'h81) begin bad++; $display("FAIL rst_first_byte got=%h want=81", bus_a.vram_d); end
  endtask

  task automatic test_direct();
    do_reset();
    shift_en = 1'b0;
    din_a = 16'hA55A;
    din_b = $urandom;
    cas_cycle(0);
    total++;
    if (bus_a.vram_d !== 8'h5A) begin bad++; $display("FAIL direct_b0 got=%h want=5A", bus_a.vram_d); end
    cas_cycle(0);
    total++;
    if (bus_a.vram_d !== 8'hA5) begin bad++; $display("FAIL direct_b1 got=%h want=A5", bus_a.vram_d); end
  endtask

  task automatic test_shift1();
    logic [7:0] exp_a [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
    do_reset();
    shift_en = 1'b1;
    shift_cnt = 4'd1;
    din_a = 16'h2211;
    din_b = $urandom;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) din_a = 16'h4433;
      cas_cycle(0);
      total++;
      if (bus_a.vram_d !== exp_a[i]) begin bad++; $display("FAIL shift1_%0d got=%h want=%h", i, bus_a.vram_d, exp_a[i]); end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] exp_b [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    shift_en = 1'b1;
    shift_cnt = 4'd9;
    din_b = 32'h44332211;
    din_a = $urandom;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) din_b = 32'h88776655;
      cas_cycle(0);
      total++;
      if (bus_b.vram_d !== exp_b[i]) begin bad++; $display("FAIL clamp_%0d got=%h want=%h", i, bus_b.vram_d, exp_b[i]); end
    end
  endtask

  task automatic test_mask();
`ifdef VRAM_FETCH_BLANK_MASK_EN
    logic [7:0] exp_a [4] = '{8'h00, 8'h00, 8'h00, 8'hCC};
`else
    logic [7:0] exp_a [4] = '{8'h00, 8'hAA, 8'hBB, 8'hCC};
`endif
    do_reset();
    shift_en = 1'b1;
    shift_cnt = 4'd1;
    crtc_de = 1'b0;
    din_a = 16'hBBAA;
    din_b = $urandom;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin crtc_de = 1'b1; din_a = 16'hDDCC; end
      cas_cycle(0);
      total++;
      if (bus_a.vram_d !== exp_a[i]) begin bad++; $display("FAIL mask_%0d got=%h want=%h", i, bus_a.vram_d, exp_a[i]); end
    end
    crtc_de = 1'b1;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [5] = '{8'hE7, 8'hC3, 8'hE7, 8'hC3, 8'hE7};
    logic [7:0] exp_b [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
    do_reset();
    shift_en = 1'b0;
    din_a = 16'hC3E7;
    din_b = 32'hDDCCBBAA;
    for (int i = 0; i < 5; i++) begin
      cas_cycle(0);
      total += 2;
      if (bus_a.vram_d !== exp_a[i]) begin bad++; $display("FAIL wrap_a_%0d got=%h want=%h", i, bus_a.vram_d, exp_a[i]); end
      if (bus_b.vram_d !== exp_b[i]) begin bad++; $display("FAIL wrap_b_%0d got=%h want=%h", i, bus_b.vram_d, exp_b[i]); end
    end
  endtask

  task automatic test_cpu_slot();
    logic [14:0] held;
    do_reset();
    shift_en = 1'b0;
    din_a = 16'h6996;
    din_b = 32'h04030201;
    crtc_ma = 14'h2ABC;
    crtc_ra = 5'h05;
    cas_cycle(0);
    held = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
    @(negedge clk);
    cpu_n = 1'b0;
    crtc_ma = 14'h1555;
    crtc_ra = 5'h1A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cas_n = (i == 0 || i == 1) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      total += 3;
      if (bus_a.byte_strobe !== 1'b0) begin bad++; $display("FAIL cpu_strobe got=%b want=0", bus_a.byte_strobe); end
      if (bus_a.vram_d !== 8'h96) begin bad++; $display("FAIL cpu_hold_d got=%h want=96", bus_a.vram_d); end
      if (bus_a.vram_addr !== held) begin bad++; $display("FAIL cpu_hold_addr got=%h want=%h", bus_a.vram_addr, held); end
    end
    @(negedge clk);
    cpu_n = 1'b1;
    idx_a = 0;
    idx_b = 0;
    cas_cycle(0);
    total += 2;
    if (bus_a.vram_d !== 8'h96) begin bad++; $display("FAIL cpu_restart_a got=%h want=96", bus_a.vram_d); end
    if (bus_b.vram_d !== 8'h01) begin bad++; $display("FAIL cpu_restart_b got=%h want=01", bus_b.vram_d); end
    cas_cycle(0);
    cas_cycle(1);
    cas_cycle(0);
    total += 2;
    if (bus_a.vram_d !== 8'h96) begin bad++; $display("FAIL cpu_clear_wins_a got=%h want=96", bus_a.vram_d); end
    if (bus_b.vram_d !== 8'h01) begin bad++; $display("FAIL cpu_clear_wins_b got=%h want=01", bus_b.vram_d); end
  endtask

  task automatic test_addr();
    logic [14:0] exp;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cpu_n = 1'b1;
      crtc_ma = 14'($urandom);
      crtc_ra = 5'($urandom);
      exp = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0]};
      @(posedge clk); #1;
      total++;
      if (bus_b.vram_addr !== exp) begin bad++; $display("FAIL addr got=%h want=%h", bus_b.vram_addr, exp); end
      @(negedge clk);
      cpu_n = 1'b0;
      crtc_ma = 14'($urandom);
      crtc_ra = 5'($urandom);
      @(posedge clk); #1;
      total++;
      if (bus_a.vram_addr !== exp) begin bad++; $display("FAIL addr_hold got=%h want=%h", bus_a.vram_addr, exp); end
    end
    @(negedge clk);
    cpu_n = 1'b1;
    idx_a = 0;
    idx_b = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      din_a = 16'($urandom);
      din_b = $urandom;
      shift_en = 1'($urandom);
      shift_cnt = 4'($urandom);
      crtc_de = ($urandom_range(0, 3) != 0);
      cas_cycle($urandom_range(0, 7) == 0);
    end
    crtc_de = 1'b1;
  endtask

  initial begin
    cpu_n = 1'b1;
    ras_n = 1'b0;
    cas_n = 1'b1;
    crtc_de = 1'b1;
    shift_en = 1'b0;
    shift_cnt = 4'd0;
    crtc_ma = 14'h0123;
    crtc_ra = 5'h03;
    din_a = 16'h0;
    din_b = 32'h0;
    model_reset();
    test_reset();
    test_direct();
    test_shift1();
    test_clamp();
    test_mask();
    test_wrap();
    test_cpu_slot();
    test_addr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
